// File: rtl/uart_rx_cfg_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_rx_cfg_if                                              |
// | Brief  : Serial line, arm strobe and status/data bundle of the       |
// |          configurable UART receiver.                                 |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
interface uart_rx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic                 din;
    logic                 start_rx;
    logic                 busy;
    logic                 rx_done;
    logic                 is_byte_valid;
    logic                 is_byte_corrupt;
    logic                 is_frame_error;
    logic                 is_rx_timeout;
    logic [DATA_BITS-1:0] dout;

    modport master (
        output din, start_rx,
        input  busy, rx_done, is_byte_valid, is_byte_corrupt,
               is_frame_error, is_rx_timeout, dout
    );

    modport slave (
        input  din, start_rx,
        output busy, rx_done, is_byte_valid, is_byte_corrupt,
               is_frame_error, is_rx_timeout, dout
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_rx_cfg                                                 |
// | Brief  : Armed UART receiver with configurable framing, start-bit    |
// |          glitch rejection, parity/stop checks and start timeout.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT   = 8,
    parameter int DATA_BITS      = 8,
    parameter int PARITY_MODE    = 1,
    parameter int STOP_BITS      = 2,
    parameter int ALIGN_STAGES   = 5,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  wire          clk,
    input  wire          rst_n,
    uart_rx_cfg_if.slave rx
);

    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_BITS + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_MID  = c_BAUD_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);
    localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_WAIT_START  = 3'd1,
        S_CHECK_START = 3'd2,
        S_DATA        = 3'd3,
        S_PARITY      = 3'd4,
        S_STOP        = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    state_t                  r_state;
    logic [ALIGN_STAGES-1:0] r_align;
    logic [c_BAUD_W-1:0]     r_baud;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [c_TO_W-1:0]       r_to_cnt;
    logic                    r_par_err;
    logic                    r_frm_err;
    logic                    r_busy;
    logic                    r_rx_done;
    logic                    r_valid;
    logic                    r_corrupt;
    logic                    r_frame;
    logic                    r_timeout;
    logic [DATA_BITS-1:0]    r_dout;

    logic w_din_fall;
    logic w_bit;
    logic w_par_x;
    logic w_par_err;

    // Edge detect and sampling both tap the two oldest alignment stages.
    assign w_din_fall = ~r_align[ALIGN_STAGES-2] & r_align[ALIGN_STAGES-1];
    assign w_bit      = r_align[ALIGN_STAGES-2];
    assign w_par_x    = (^r_dout) ^ w_bit;
    assign w_par_err  = (PARITY_MODE == 1) ? ~w_par_x : w_par_x;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_align   <= '1;
            r_baud    <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_busy    <= 1'b0;
            r_rx_done <= 1'b0;
            r_valid   <= 1'b0;
            r_corrupt <= 1'b0;
            r_frame   <= 1'b0;
            r_timeout <= 1'b0;
            r_dout    <= '0;
        end else begin
            r_align   <= {r_align[ALIGN_STAGES-2:0], rx.din};
            r_rx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx.start_rx) begin
                        r_valid   <= 1'b0;
                        r_corrupt <= 1'b0;
                        r_frame   <= 1'b0;
                        r_timeout <= 1'b0;
                        r_dout    <= '0;
                        r_to_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_par_err <= 1'b0;
                        r_frm_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT_START;
                    end
                end
                S_WAIT_START: begin
                    if (w_din_fall) begin
                        r_baud  <= '0;
                        r_state <= S_CHECK_START;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        r_timeout <= 1'b1;
                        r_rx_done <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_CHECK_START: begin
                    // A line that is high again mid start bit was a glitch;
                    // the timeout budget keeps running from where it was.
                    if (r_baud == c_BAUD_MID) begin
                        r_baud  <= '0;
                        r_state <= w_bit ? S_WAIT_START : S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud <= '0;
                        r_dout <= {w_bit, r_dout[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_DATA_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud    <= '0;
                        r_par_err <= w_par_err;
                        r_state   <= S_STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_baud == c_BAUD_LAST) begin
                        r_baud <= '0;
                        if (!w_bit) begin
                            r_frm_err <= 1'b1;
                        end
                        if (r_bit_cnt == c_STOP_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_DONE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DONE: begin
                    r_rx_done <= 1'b1;
                    r_corrupt <= r_par_err;
                    r_frame   <= r_frm_err;
                    r_valid   <= ~r_par_err & ~r_frm_err;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx.busy            = r_busy;
    assign rx.rx_done         = r_rx_done;
    assign rx.is_byte_valid   = r_valid;
    assign rx.is_byte_corrupt = r_corrupt;
    assign rx.is_frame_error  = r_frame;
    assign rx.is_rx_timeout   = r_timeout;
    assign rx.dout            = r_dout;

endmodule
`default_nettype wire
